// File: rtl/gate_check_pkg.sv
// Shared types and sizing for the gate block sweep checker.
package gate_check_pkg;

   localparam int NUM_OUT = 7;
   localparam int NUM_VEC = 4;
   localparam int ERR_W   = 5;

   // ST_ prefix keeps SETTLE free for the checker's settle-time parameter.
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_SAMPLE,
      ST_DONE
   } state_t;

endpackage

// File: rtl/gate_expect.sv
// Golden truth table of the two-input gate block: {a,b} -> Y0..Y6.
module gate_expect
   import gate_check_pkg::*;
(
   input  logic               a,
   input  logic               b,
   output logic [NUM_OUT-1:0] y
);

   always_comb begin
      y    = '0;
      y[0] = a & b;
      y[1] = a | b;
      y[2] = a;
      y[3] = ~(a & b);
      y[4] = ~(a | b);
      y[5] = a ^ b;
      y[6] = ~(a ^ b);
   end

endmodule

// File: rtl/gate_sweep_checker.sv
// Drives the gate block through all four {A,B} vectors, samples Y after SETTLE
// idle cycles and accumulates a sticky per-output fail mask and bit error count.
module gate_sweep_checker
   import gate_check_pkg::*;
#(
   parameter int SETTLE = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [NUM_OUT-1:0] Y,
   output logic               A,
   output logic               B,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [NUM_OUT-1:0] fail_mask,
   output logic [ERR_W-1:0]   err_count
);

   localparam logic [3:0] SETTLE_L = 4'(SETTLE);
   // With no settle time every cycle is a sample cycle.
   localparam state_t FIRST_ST = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
   localparam logic [1:0] LAST_VEC = 2'(NUM_VEC - 1);

   state_t             state, state_nxt;
   logic [1:0]         vec, vec_nxt;
   logic [3:0]         cnt, cnt_nxt;
   logic [NUM_OUT-1:0] mask_nxt;
   logic [ERR_W-1:0]   err_nxt;
   logic [NUM_OUT-1:0] expected;
   logic [NUM_OUT-1:0] diff;
   logic [ERR_W-1:0]   diff_cnt;

   gate_expect u_expect (
      .a (vec[1]),
      .b (vec[0]),
      .y (expected)
   );

   always_comb begin
      diff     = Y ^ expected;
      diff_cnt = '0;
      for (int i = 0; i < NUM_OUT; i++)
         diff_cnt = diff_cnt + ERR_W'(diff[i]);
   end

   always_comb begin
      state_nxt = state;
      vec_nxt   = vec;
      cnt_nxt   = cnt;
      mask_nxt  = fail_mask;
      err_nxt   = err_count;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_nxt = FIRST_ST;
               vec_nxt   = '0;
               cnt_nxt   = SETTLE_L;
               mask_nxt  = '0;
               err_nxt   = '0;
            end
         end
         ST_SETTLE: begin
            // Counter holds the remaining settle cycles including this one.
            cnt_nxt = cnt - 4'd1;
            if (cnt <= 4'd1)
               state_nxt = ST_SAMPLE;
         end
         ST_SAMPLE: begin
            mask_nxt = fail_mask | diff;
            err_nxt  = err_count + diff_cnt;
            if (vec == LAST_VEC) begin
               state_nxt = ST_DONE;
            end else begin
               vec_nxt   = vec + 2'd1;
               cnt_nxt   = SETTLE_L;
               state_nxt = FIRST_ST;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         vec       <= '0;
         cnt       <= '0;
         fail_mask <= '0;
         err_count <= '0;
      end else begin
         state     <= state_nxt;
         vec       <= vec_nxt;
         cnt       <= cnt_nxt;
         fail_mask <= mask_nxt;
         err_count <= err_nxt;
      end
   end

   // vec is the registered stimulus, so A/B change on the same edge as vec.
   assign A    = vec[1];
   assign B    = vec[0];
   assign busy = (state == ST_SETTLE) || (state == ST_SAMPLE);
   assign done = (state == ST_DONE);
   assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: one instance with SETTLE=2, one with SETTLE=0,
// each driving a gate model with injectable stuck-at-0 outputs.
module tb_gate_sweep_checker;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_v   [2];
   logic       start_v [2];
   logic [6:0] fault_v [2];
   logic [6:0] y_v     [2];
   logic       a_v     [2];
   logic       b_v     [2];
   logic       busy_v  [2];
   logic       done_v  [2];
   logic       pass_v  [2];
   logic [6:0] mask_v  [2];
   logic [4:0] err_v   [2];

   int         t_m     [2];
   logic [6:0] mforce  [2];
   int         n_tests = 0;
   int         n_fail  = 0;

   gate_sweep_checker #(.SETTLE(2)) u_dut2 (
      .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .Y(y_v[0]),
      .A(a_v[0]), .B(b_v[0]), .busy(busy_v[0]), .done(done_v[0]),
      .pass(pass_v[0]), .fail_mask(mask_v[0]), .err_count(err_v[0])
   );

   gate_sweep_checker #(.SETTLE(0)) u_dut0 (
      .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .Y(y_v[1]),
      .A(a_v[1]), .B(b_v[1]), .busy(busy_v[1]), .done(done_v[1]),
      .pass(pass_v[1]), .fail_mask(mask_v[1]), .err_count(err_v[1])
   );

   // Truth table written out by hand, bit order Y6..Y0, indexed by {A,B}.
   function automatic logic [6:0] gold(input logic [1:0] ab);
      case (ab)
         2'd0:    return 7'b1011000;
         2'd1:    return 7'b0101010;
         2'd2:    return 7'b0101110;
         default: return 7'b1000111;
      endcase
   endfunction

   function automatic int settle_of(input int d);
      return (d == 0) ? 2 : 0;
   endfunction

   always_comb begin
      for (int d = 0; d < 2; d++)
         y_v[d] = gold({a_v[d], b_v[d]}) & ~fault_v[d];
   end

   // Model: t_m = edges since the accepted start (-1 idle after reset, -2 not yet reset).
   task automatic check_dut(input int d);
      int         tp, k, e;
      logic [6:0] m, df;
      logic       bz, dn, ep;
      tp = settle_of(d) + 1;
      k  = 0; e = 0; m = '0; bz = 1'b0; dn = 1'b0;
      if (t_m[d] != -2) begin
         if (t_m[d] >= 0) begin
            bz = (t_m[d] < 4 * tp);
            dn = !bz;
            k  = t_m[d] / tp;
            if (k > 3) k = 3;
            for (int j = 0; j < 4; j++) begin
               if (j * tp + settle_of(d) + 1 <= t_m[d]) begin
                  df = gold(2'(j)) & mforce[d];
                  m  = m | df;
                  e  = e + $countones(df);
               end
            end
         end
         ep = dn && (e == 0);
         n_tests++;
         if ({a_v[d], b_v[d]} !== 2'(k) || busy_v[d] !== bz || done_v[d] !== dn ||
             pass_v[d] !== ep || mask_v[d] !== m || err_v[d] !== 5'(e)) begin
            n_fail++;
            $display("FAIL cycle dut%0d t=%0d: got ab=%b busy=%b done=%b pass=%b mask=%b err=%0d, want ab=%b busy=%b done=%b pass=%b mask=%b err=%0d",
                     d, t_m[d], {a_v[d], b_v[d]}, busy_v[d], done_v[d], pass_v[d], mask_v[d], err_v[d],
                     2'(k), bz, dn, ep, m, e);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
         if (rst_v[d]) begin
            t_m[d] = -1;
         end else if (t_m[d] != -2) begin
            if (start_v[d] && !(t_m[d] >= 0 && t_m[d] < 4 * (settle_of(d) + 1))) begin
               t_m[d]    = 0;
               mforce[d] = fault_v[d];
            end else if (t_m[d] >= 0 && t_m[d] < 1000) begin
               t_m[d]++;
            end
         end
      end
      @(negedge clk);
      check_dut(0);
      check_dut(1);
   endtask

   task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", nm, got, want);
      end
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         rst_v[d] = 1'b1; start_v[d] = 1'b0; fault_v[d] = '0;
         t_m[d] = -2; mforce[d] = '0;
      end
      tick();
      tick();
      rst_v[0] = 1'b0; rst_v[1] = 1'b0;
      tick();
      lit("reset_busy", busy_v[0], 0);
      lit("reset_done", done_v[0], 0);
      lit("reset_err",  err_v[0],  0);
      lit("reset_ab",   {a_v[0], b_v[0]}, 0);

      // Correct gate, single start pulse.
      start_v[0] = 1'b1; tick(); start_v[0] = 1'b0;
      lit("t1_ab_e0",   {a_v[0], b_v[0]}, 0);
      lit("t1_busy_e0", busy_v[0], 1);
      repeat (11) tick();
      lit("t1_done_e11", done_v[0], 0);
      tick();
      lit("t1_done_e12", done_v[0], 1);
      lit("t1_pass",     pass_v[0], 1);
      lit("t1_mask",     mask_v[0], 0);
      lit("t1_err",      err_v[0],  0);

      // Y5 stuck at 0.
      fault_v[0] = 7'b0100000;
      start_v[0] = 1'b1; tick(); start_v[0] = 1'b0;
      repeat (12) tick();
      lit("t2_done", done_v[0], 1);
      lit("t2_mask", mask_v[0], 7'b0100000);
      lit("t2_err",  err_v[0],  2);
      lit("t2_pass", pass_v[0], 0);

      // Every output stuck at 0.
      fault_v[0] = 7'h7f;
      start_v[0] = 1'b1; tick(); start_v[0] = 1'b0;
      repeat (12) tick();
      lit("t3_mask", mask_v[0], 7'h7f);
      lit("t3_err",  err_v[0],  14);
      lit("t3_pass", pass_v[0], 0);

      // SETTLE=0 instance, second start pulse while busy.
      fault_v[1] = '0;
      start_v[1] = 1'b1; tick(); start_v[1] = 1'b0;
      lit("t4_busy_e0", busy_v[1], 1);
      tick();
      start_v[1] = 1'b1; tick(); start_v[1] = 1'b0;
      tick();
      lit("t4_done_e3", done_v[1], 0);
      tick();
      lit("t4_done_e4", done_v[1], 1);
      lit("t4_pass",    pass_v[1], 1);
      tick();
      lit("t4_done_e5", done_v[1], 1);

      // Reset in the middle of a failing sweep.
      fault_v[0] = 7'h7f;
      start_v[0] = 1'b1; tick(); start_v[0] = 1'b0;
      repeat (4) tick();
      lit("t5_err_pre", err_v[0], 3);
      rst_v[0] = 1'b1; tick(); rst_v[0] = 1'b0;
      lit("t5_err",  err_v[0],  0);
      lit("t5_mask", mask_v[0], 0);
      lit("t5_busy", busy_v[0], 0);
      lit("t5_ab",   {a_v[0], b_v[0]}, 0);
      fault_v[0] = '0;
      start_v[0] = 1'b1; tick(); start_v[0] = 1'b0;
      repeat (12) tick();
      lit("t5_done", done_v[0], 1);
      lit("t5_pass", pass_v[0], 1);

      // start held high across two sweeps.
      fault_v[0] = 7'b0100000;
      start_v[0] = 1'b1; tick();
      repeat (12) tick();
      lit("t6_done_e12", done_v[0], 1);
      lit("t6_err_e12",  err_v[0],  2);
      fault_v[0] = '0;
      tick();
      lit("t6_done_e13", done_v[0], 0);
      lit("t6_busy_e13", busy_v[0], 1);
      lit("t6_err_e13",  err_v[0],  0);
      repeat (12) tick();
      lit("t6_done_e25", done_v[0], 1);
      lit("t6_pass_e25", pass_v[0], 1);
      start_v[0] = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
